// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, bit positions and
// the EPC alignment helper used when an exception is taken.
package cp0_pkg;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int unsigned SR_IE     = 0;
   localparam int unsigned SR_EXL    = 1;
   localparam int unsigned IM_BASE   = 10;
   localparam int unsigned IP_BASE   = 10;
   localparam int unsigned CAUSE_TI  = 30;
   localparam int unsigned CAUSE_BD  = 31;
   localparam int unsigned INT_LINES = 6;

   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

   // A delay-slot instruction restarts at its branch, one word earlier.
   function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
      logic [31:0] tgt;
      tgt = bd ? (pc - 32'd4) : pc;
      return {tgt[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running counter with a sticky match flag that is
// cleared only by writing Compare.
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        we_count,
   input  logic        we_compare,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic [31:0] count_r;
   logic [31:0] compare_r;
   logic        ti_r;

   // Counter, compare register and sticky match flag (Compare write beats a match).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r   <= 32'd0;
         compare_r <= 32'd0;
         ti_r      <= 1'b0;
      end else begin
         count_r <= we_count ? wdata : (count_r + 32'd1);
         if (we_compare) begin
            compare_r <= wdata;
            ti_r      <= 1'b0;
         end else if (count_r == compare_r) begin
            ti_r <= 1'b1;
         end
      end
   end

   assign count   = count_r;
   assign compare = compare_r;
   assign ti      = ti_r;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 beside the M stage: interrupt/exception arbitration, EPC/Cause
// capture with delay-slot correction, mfc0/mtc0/eret and optional timer.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter int          NUM_HWINT = 6,
   parameter bit          TIMER_EN  = 1'b1,
   parameter logic [31:0] PRID      = 32'h4D49_5053
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [4:0]           addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   input  logic [31:0]          pc_m,
   input  logic                 bd_m,
   input  logic                 exc_m,
   input  logic [4:0]           exc_code_m,
   input  logic                 eret_m,
   input  logic [NUM_HWINT-1:0] hw_int,
   output logic                 int_req,
   output logic [31:0]          epc
);

   logic [5:0]  im_r;
   logic [5:0]  hw_ip_r;
   logic        exl_r;
   logic        ie_r;
   logic        bd_r;
   logic [4:0]  exc_code_r;
   logic [31:0] epc_r;

   logic [5:0]  hw_pad_s;
   logic [5:0]  ip_s;
   logic        int_pend_s;
   logic        exc_take_s;
   logic        int_req_s;
   logic        wr_s;
   logic [31:0] count_s;
   logic [31:0] compare_s;
   logic        ti_s;
   logic [31:0] sr_s;
   logic [31:0] cause_s;

   assign hw_pad_s = 6'(hw_int);
   assign ip_s     = {hw_ip_r[5] | ti_s, hw_ip_r[4:0]};

   // EXL blocks both sources, which also masks everything during the eret cycle.
   assign int_pend_s = (|(ip_s & im_r)) & ie_r & ~exl_r;
   assign exc_take_s = exc_m & ~exl_r;
   assign int_req_s  = int_pend_s | exc_take_s;
   assign wr_s       = we & ~int_req_s;

   generate
      if (TIMER_EN) begin : g_timer
         cp0_timer u_timer (
            .clk       (clk),
            .reset     (reset),
            .we_count  (wr_s && (addr == REG_COUNT)),
            .we_compare(wr_s && (addr == REG_COMPARE)),
            .wdata     (wdata),
            .count     (count_s),
            .compare   (compare_s),
            .ti        (ti_s)
         );
      end else begin : g_no_timer
         assign count_s   = 32'd0;
         assign compare_s = 32'd0;
         assign ti_s      = 1'b0;
      end
   endgenerate

   assign sr_s    = {16'd0, im_r, 8'd0, exl_r, ie_r};
   assign cause_s = {bd_r, ti_s, 14'd0, ip_s, 3'd0, exc_code_r, 2'd0};

   // Exception entry, mtc0 updates and eret; mtc0 is dropped when an exception is taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_r       <= 6'd0;
         hw_ip_r    <= 6'd0;
         exl_r      <= 1'b0;
         ie_r       <= 1'b0;
         bd_r       <= 1'b0;
         exc_code_r <= 5'd0;
         epc_r      <= 32'd0;
      end else begin
         hw_ip_r <= hw_pad_s;
         if (int_req_s) begin
            exl_r      <= 1'b1;
            exc_code_r <= int_pend_s ? EXC_INT : exc_code_m;
            bd_r       <= bd_m;
            epc_r      <= epc_target(pc_m, bd_m);
         end else begin
            if (we && (addr == REG_SR)) begin
               im_r  <= wdata[IM_BASE +: INT_LINES];
               exl_r <= wdata[SR_EXL];
               ie_r  <= wdata[SR_IE];
            end
            if (we && (addr == REG_EPC)) begin
               epc_r <= {wdata[31:2], 2'b00};
            end
            if (eret_m) begin
               exl_r <= 1'b0;
            end
         end
      end
   end

   // mfc0 read mux.
   always_comb begin
      rdata = 32'd0;
      case (addr)
         REG_COUNT:   rdata = count_s;
         REG_COMPARE: rdata = compare_s;
         REG_SR:      rdata = sr_s;
         REG_CAUSE:   rdata = cause_s;
         REG_EPC:     rdata = epc_r;
         REG_PRID:    rdata = PRID;
         default:     rdata = 32'd0;
      endcase
   end

   assign int_req = int_req_s;
   assign epc     = epc_r;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: a full build and a reduced build (2 lines, no timer)
// share the CP0 write/read bus.
module tb_cp0_unit;

   logic        clk;
   logic        reset;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] rdata_sm;
   logic [31:0] pc_m;
   logic        bd_m;
   logic        exc_m;
   logic [4:0]  exc_code_m;
   logic        eret_m;
   logic [5:0]  hw_int;
   logic        int_req;
   logic        int_req_sm;
   logic [31:0] epc;
   logic [31:0] epc_sm;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] PRID_V = 32'h4D49_5053;

   cp0_unit u_dut (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
      .pc_m(pc_m), .bd_m(bd_m), .exc_m(exc_m), .exc_code_m(exc_code_m), .eret_m(eret_m),
      .hw_int(hw_int), .int_req(int_req), .epc(epc)
   );

   cp0_unit #(.NUM_HWINT(2), .TIMER_EN(1'b0)) u_small (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata_sm),
      .pc_m(pc_m), .bd_m(bd_m), .exc_m(exc_m), .exc_code_m(exc_code_m), .eret_m(eret_m),
      .hw_int(hw_int[1:0]), .int_req(int_req_sm), .epc(epc_sm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      step();
      we = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a);
      addr = a;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      rd(5'd12);
      n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_sr: got %h want %h", rdata, 32'd0); end
      n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int_req: got %b want 0", int_req); end
      n_checks++; if (epc !== 32'd0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", epc); end
      reset = 1'b0;
      // Compare write on the first cycle beats the Count==Compare(0) match.
      mtc0(5'd11, 32'hFFFF_0000);
      rd(5'd13);
      n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL compare_write_wins: got %h want %h", rdata, 32'd0); end
   endtask

   task automatic test_hw_interrupt();
      mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'b000001; pc_m = 32'h0000_2000; bd_m = 1'b0;
      #1;
      n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL hw_before_sample: got %b want 0", int_req); end
      step();
      n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL hw_int_req: got %b want 1", int_req); end
      step();
      n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL hw_req_drop: got %b want 0", int_req); end
      n_checks++; if (epc !== 32'h0000_2000) begin n_fail++; $display("FAIL hw_epc: got %h want %h", epc, 32'h0000_2000); end
      rd(5'd12);
      n_checks++; if (rdata !== 32'h0000_0403) begin n_fail++; $display("FAIL hw_sr: got %h want %h", rdata, 32'h0000_0403); end
      rd(5'd13);
      n_checks++; if (rdata !== 32'h0000_0400) begin n_fail++; $display("FAIL hw_cause: got %h want %h", rdata, 32'h0000_0400); end
      hw_int = 6'd0;
   endtask

   task automatic test_exception_bd();
      mtc0(5'd12, 32'h0000_0000);
      exc_m = 1'b1; exc_code_m = 5'd12; bd_m = 1'b1; pc_m = 32'h0000_3010;
      #1;
      n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL exc_int_req: got %b want 1", int_req); end
      step();
      exc_m = 1'b0; bd_m = 1'b0;
      n_checks++; if (epc !== 32'h0000_300C) begin n_fail++; $display("FAIL exc_epc_bd: got %h want %h", epc, 32'h0000_300C); end
      rd(5'd13);
      n_checks++; if (rdata !== 32'h8000_0030) begin n_fail++; $display("FAIL exc_cause: got %h want %h", rdata, 32'h8000_0030); end
      rd(5'd12);
      n_checks++; if (rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL exc_sr: got %h want %h", rdata, 32'h0000_0002); end
   endtask

   task automatic test_no_nesting_eret();
      mtc0(5'd12, 32'h0000_0403);
      hw_int = 6'b000001; exc_m = 1'b1; exc_code_m = 5'd4; pc_m = 32'h0000_3100;
      step();
      n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_blocked: got %b want 0", int_req); end
      n_checks++; if (epc !== 32'h0000_300C) begin n_fail++; $display("FAIL nest_epc_kept: got %h want %h", epc, 32'h0000_300C); end
      exc_m = 1'b0; eret_m = 1'b1;
      #1;
      n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL eret_cycle: got %b want 0", int_req); end
      step();
      eret_m = 1'b0; pc_m = 32'h0000_4000;
      #1;
      n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL after_eret: got %b want 1", int_req); end
      step();
      hw_int = 6'd0;
      n_checks++; if (epc !== 32'h0000_4000) begin n_fail++; $display("FAIL after_eret_epc: got %h want %h", epc, 32'h0000_4000); end
   endtask

   task automatic test_mtc0_suppressed();
      mtc0(5'd12, 32'h0000_0001);
      exc_m = 1'b1; exc_code_m = 5'd10; pc_m = 32'h0000_5000;
      we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC01;
      #1;
      n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL sup_int_req: got %b want 1", int_req); end
      step();
      we = 1'b0; exc_m = 1'b0;
      rd(5'd12);
      n_checks++; if (rdata !== 32'h0000_0003) begin n_fail++; $display("FAIL sup_sr: got %h want %h", rdata, 32'h0000_0003); end
      n_checks++; if (epc !== 32'h0000_5000) begin n_fail++; $display("FAIL sup_epc: got %h want %h", epc, 32'h0000_5000); end
      mtc0(5'd14, 32'h0000_6007);
      n_checks++; if (epc !== 32'h0000_6004) begin n_fail++; $display("FAIL epc_write_align: got %h want %h", epc, 32'h0000_6004); end
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd(5'd13);
      n_checks++; if (rdata !== 32'h0000_0028) begin n_fail++; $display("FAIL cause_readonly: got %h want %h", rdata, 32'h0000_0028); end
      mtc0(5'd15, 32'h0000_0000);
      rd(5'd15);
      n_checks++; if (rdata !== PRID_V) begin n_fail++; $display("FAIL prid: got %h want %h", rdata, PRID_V); end
   endtask

   task automatic test_timer();
      mtc0(5'd9, 32'hFFFF_FFFE);
      mtc0(5'd11, 32'h0000_0001);
      mtc0(5'd12, 32'h0000_8001);
      rd(5'd9);
      n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL count_wrap: got %h want %h", rdata, 32'd0); end
      n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL timer_idle: got %b want 0", int_req); end
      step();
      n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL timer_early: got %b want 0", int_req); end
      step();
      n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL timer_int_req: got %b want 1", int_req); end
      rd(5'd9);
      n_checks++; if (rdata !== 32'd2) begin n_fail++; $display("FAIL count_inc: got %h want %h", rdata, 32'd2); end
      rd(5'd13);
      n_checks++; if (rdata !== 32'h4000_8028) begin n_fail++; $display("FAIL timer_cause: got %h want %h", rdata, 32'h4000_8028); end
      pc_m = 32'h0000_7000;
      step();
      rd(5'd13);
      n_checks++; if (rdata !== 32'h4000_8000) begin n_fail++; $display("FAIL timer_taken_cause: got %h want %h", rdata, 32'h4000_8000); end
      n_checks++; if (epc !== 32'h0000_7000) begin n_fail++; $display("FAIL timer_epc: got %h want %h", epc, 32'h0000_7000); end
      mtc0(5'd11, 32'hFFFF_0000);
      rd(5'd13);
      n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL ti_clear: got %h want %h", rdata, 32'd0); end
   endtask

   task automatic test_async_reset();
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (epc !== 32'd0) begin n_fail++; $display("FAIL async_epc: got %h want 0", epc); end
      rd(5'd12);
      n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL async_sr: got %h want 0", rdata); end
      rd(5'd9);
      n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL async_count: got %h want 0", rdata); end
      step();
      reset = 1'b0;
   endtask

   task automatic test_params();
      hw_int = 6'h3F;
      step();
      rd(5'd13);
      n_checks++; if (rdata !== 32'h4000_FC00) begin n_fail++; $display("FAIL full_cause: got %h want %h", rdata, 32'h4000_FC00); end
      n_checks++; if (rdata_sm !== 32'h0000_0C00) begin n_fail++; $display("FAIL small_cause: got %h want %h", rdata_sm, 32'h0000_0C00); end
      rd(5'd9);
      n_checks++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL full_count: got %h want %h", rdata, 32'd1); end
      n_checks++; if (rdata_sm !== 32'd0) begin n_fail++; $display("FAIL small_count: got %h want 0", rdata_sm); end
      n_checks++; if (int_req_sm !== 1'b0) begin n_fail++; $display("FAIL small_int_req: got %b want 0", int_req_sm); end
      rd(5'd15);
      n_checks++; if (rdata_sm !== PRID_V) begin n_fail++; $display("FAIL small_prid: got %h want %h", rdata_sm, PRID_V); end
      hw_int = 6'd0;
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; addr = 5'd0; wdata = 32'd0; pc_m = 32'd0; bd_m = 1'b0;
      exc_m = 1'b0; exc_code_m = 5'd0; eret_m = 1'b0; hw_int = 6'd0;
      test_reset();
      test_hw_interrupt();
      test_exception_bd();
      test_no_nesting_eret();
      test_mtc0_suppressed();
      test_timer();
      test_async_reset();
      test_params();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
